// File: rtl/mmio_pkg.sv
// mmio_pkg: shared IO-map offsets and widths for mmio_hub and its input path.
package mmio_pkg;
  // Buttons per controller channel
  localparam int BTN_W = 8;

  // IO-region offsets (address[7:0] when the IO region is selected)
  localparam logic [7:0] CTRL_BASE  = 8'h00;
  localparam logic [7:0] PRESS_BASE = 8'h10;
  localparam logic [7:0] PVGA_BASE  = 8'h20;
  localparam logic [7:0] STAGE_LO   = 8'h40;
  localparam logic [7:0] STAGE_HI   = 8'h41;
  localparam logic [7:0] FRAME_CNT  = 8'h7E;
  localparam logic [7:0] COMMIT     = 8'h7F;

  // The top word-address bit selects the IO region over data RAM
  function automatic int io_bit(input int addr_width);
    return addr_width - 1;
  endfunction
endpackage

// File: rtl/mmio_hub_input_sync.sv
// input_sync: one controller channel. Synchronises the raw buttons, optionally
// debounces them (MMIO_DEBOUNCE_EN) and produces a one-cycle rising-edge strobe.
module input_sync
  import mmio_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [BTN_W-1:0] raw,
  output logic [BTN_W-1:0] state,
  output logic [BTN_W-1:0] rise
);
  logic [SYNC_STAGES-1:0][BTN_W-1:0] sync_reg;
  logic [BTN_W-1:0]                  synced;
  logic [BTN_W-1:0]                  filt;
  logic [BTN_W-1:0]                  prev_reg;

  // Metastability chain: stage 0 samples the asynchronous pins
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg[0] <= raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_reg[i] <= sync_reg[i-1];
    end
  end

  assign synced = sync_reg[SYNC_STAGES-1];

`ifdef MMIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar gi = 0; gi < BTN_W; gi++) begin : g_db
    logic [CW-1:0] cnt_reg;
    logic          filt_reg;

    // Flip the filtered bit only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clock) begin
      if (reset) begin
        cnt_reg  <= '0;
        filt_reg <= 1'b0;
      end else if (filt_reg == synced[gi]) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_reg  <= '0;
        filt_reg <= synced[gi];
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end

    assign filt[gi] = filt_reg;
  end
`else
  // Without debouncing the window length is irrelevant; the synchronised value passes straight through
  if (DEBOUNCE_CYCLES > 0) begin : g_direct
    assign filt = synced;
  end else begin : g_direct_zero
    assign filt = synced;
  end
`endif

  // Previous filtered value for edge detection
  always_ff @(posedge clock) begin
    if (reset) prev_reg <= '0;
    else       prev_reg <= filt;
  end

  assign state = filt;
  assign rise  = filt & ~prev_reg;
endmodule

// File: rtl/mmio_hub.sv
// mmio_hub: dmem-port decoder for data RAM plus an IO region holding controller
// state/press latches, double-buffered VGA sprite/stage descriptors committed on
// vsync, and a frame counter. Optional button debouncing via MMIO_DEBOUNCE_EN.
// VGA_WIDTH is expected to be exactly two DATA_WIDTH words.
module mmio_hub
  import mmio_pkg::*;
#(
  parameter int NUM_PLAYERS     = 2,
  parameter int ADDR_WIDTH      = 13,
  parameter int DATA_WIDTH      = 32,
  parameter int RAM_DEPTH       = 4096,
  parameter int VGA_WIDTH       = 64,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            address,
  input  logic [DATA_WIDTH-1:0]            data_in,
  input  logic                             wren,
  output logic [DATA_WIDTH-1:0]            data_out,
  input  logic [NUM_PLAYERS*BTN_W-1:0]     ctrl_in,
  input  logic                             vsync,
  output logic [NUM_PLAYERS*VGA_WIDTH-1:0] player_vga,
  output logic [VGA_WIDTH-1:0]             stage_vga,
  output logic                             commit_pending,
  output logic [15:0]                      frame_count
);
  localparam int IO_BIT = io_bit(ADDR_WIDTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);

  logic [DATA_WIDTH-1:0] ram [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q_reg;
  logic                  rd_ram_reg;
  logic [DATA_WIDTH-1:0] io_q_reg;
  logic [DATA_WIDTH-1:0] io_rd;

  logic                  io_sel;
  logic [7:0]            offset;
  logic [ADDR_WIDTH-2:0] ram_idx;
  logic                  ram_hit;
  logic                  commit_wr;

  logic [NUM_PLAYERS-1:0][BTN_W-1:0] btn_state, btn_rise, press_reg, press_clr;
  logic [NUM_PLAYERS-1:0][VGA_WIDTH-1:0] pshadow_reg, plive_reg;
  logic [VGA_WIDTH-1:0] sshadow_reg, slive_reg;
  logic                 pending_reg;
  logic [15:0]          frame_reg;

  logic [SYNC_STAGES-1:0] vs_sync_reg;
  logic                   vs_prev_reg;
  logic                   vs_edge;

  assign io_sel    = address[IO_BIT];
  assign offset    = address[7:0];
  assign ram_idx   = address[ADDR_WIDTH-2:0];
  assign ram_hit   = !io_sel && (int'(ram_idx) < RAM_DEPTH);
  assign commit_wr = io_sel && wren && (offset == COMMIT);

  for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_player
    input_sync #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sync (
      .clock(clock),
      .reset(reset),
      .raw  (ctrl_in[gi*BTN_W +: BTN_W]),
      .state(btn_state[gi]),
      .rise (btn_rise[gi])
    );
  end

  // Vsync synchroniser plus previous-value flop for rising-edge detection
  always_ff @(posedge clock) begin
    if (reset) begin
      vs_sync_reg <= '0;
      vs_prev_reg <= 1'b0;
    end else begin
      vs_sync_reg[0] <= vsync;
      for (int i = 1; i < SYNC_STAGES; i++) vs_sync_reg[i] <= vs_sync_reg[i-1];
      vs_prev_reg <= vs_sync_reg[SYNC_STAGES-1];
    end
  end

  assign vs_edge = vs_sync_reg[SYNC_STAGES-1] & ~vs_prev_reg;

  // Block RAM port: registered read returns the pre-write word on a same-address write
  always_ff @(posedge clock) begin
    if (ram_hit && wren) ram[ram_idx[RAM_AW-1:0]] <= data_in;
    ram_q_reg <= ram[ram_idx[RAM_AW-1:0]];
  end

  // IO read mux; a non-write access to a press offset also requests its clear
  always_comb begin
    io_rd     = '0;
    press_clr = '0;
    if (io_sel) begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (offset == CTRL_BASE + 8'(p)) io_rd = DATA_WIDTH'(btn_state[p]);
        if (offset == PRESS_BASE + 8'(p)) begin
          io_rd = DATA_WIDTH'(press_reg[p]);
          if (!wren) press_clr[p] = '1;
        end
        if (offset == PVGA_BASE + 8'(2*p))     io_rd = pshadow_reg[p][DATA_WIDTH-1:0];
        if (offset == PVGA_BASE + 8'(2*p + 1)) io_rd = pshadow_reg[p][VGA_WIDTH-1:DATA_WIDTH];
      end
      case (offset)
        STAGE_LO:  io_rd = sshadow_reg[DATA_WIDTH-1:0];
        STAGE_HI:  io_rd = sshadow_reg[VGA_WIDTH-1:DATA_WIDTH];
        FRAME_CNT: io_rd = DATA_WIDTH'(frame_reg);
        COMMIT:    io_rd = DATA_WIDTH'(pending_reg);
        default:   ;
      endcase
    end
  end

  // Read-data staging, press latches and shadow-register writes
  always_ff @(posedge clock) begin
    if (reset) begin
      io_q_reg    <= '0;
      rd_ram_reg  <= 1'b0;
      press_reg   <= '0;
      pshadow_reg <= '0;
      sshadow_reg <= '0;
    end else begin
      io_q_reg   <= io_rd;
      rd_ram_reg <= ram_hit;
      // A new edge wins over a same-cycle clear
      press_reg  <= (press_reg & ~press_clr) | btn_rise;
      if (io_sel && wren) begin
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (offset == PVGA_BASE + 8'(2*p))     pshadow_reg[p][DATA_WIDTH-1:0]         <= data_in;
          if (offset == PVGA_BASE + 8'(2*p + 1)) pshadow_reg[p][VGA_WIDTH-1:DATA_WIDTH] <= data_in;
        end
        if (offset == STAGE_LO) sshadow_reg[DATA_WIDTH-1:0]         <= data_in;
        if (offset == STAGE_HI) sshadow_reg[VGA_WIDTH-1:DATA_WIDTH] <= data_in;
      end
    end
  end

  // Atomic shadow-to-live commit on vsync; copy sees shadows from before this cycle's write
  always_ff @(posedge clock) begin
    if (reset) begin
      plive_reg   <= '0;
      slive_reg   <= '0;
      pending_reg <= 1'b0;
      frame_reg   <= '0;
    end else begin
      if (vs_edge) frame_reg <= frame_reg + 16'd1;
      if (vs_edge && pending_reg) begin
        plive_reg   <= pshadow_reg;
        slive_reg   <= sshadow_reg;
        pending_reg <= commit_wr;
      end else if (commit_wr) begin
        pending_reg <= 1'b1;
      end
    end
  end

  assign data_out       = rd_ram_reg ? ram_q_reg : io_q_reg;
  assign player_vga     = plive_reg;
  assign stage_vga      = slive_reg;
  assign commit_pending = pending_reg;
  assign frame_count    = frame_reg;
endmodule
